clock_set_controller: RTL and testbench

- Sequencing controller for the HH:MM:SS clock datapath.
- Generates the 1 Hz tick and owns the BCD time registers.
- Runs a RUN / SET_HOUR / SET_MIN mode FSM driven by two buttons.
- Schedules time-multiplexed sharing of the single seven-segment decoder across four digits (HH:MM), blanking the field being edited.

---
 rtl/clock_set_controller.sv | 163 ++++++++++++++++
 tb/tb_clock_set_controller.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/clock_set_controller.sv
// HH:MM:SS clock controller: 1 Hz prescaler, BCD time registers, RUN/SET_HOUR/SET_MIN mode FSM
// and a four-digit (HH:MM) scan scheduler with field blinking while editing.
module clock_set_controller #(
    parameter int TICK_DIV = 50000000,
    parameter int SCAN_DIV = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_mode,
    input  logic       btn_inc,
    output logic [7:0] hour_bcd,
    output logic [7:0] min_bcd,
    output logic [7:0] sec_bcd,
    output logic [1:0] mode,
    output logic       tick,
    output logic       led,
    output logic [3:0] digit_sel,
    output logic [3:0] digit_val
);

    localparam int PW = $clog2(TICK_DIV);
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        SET_HOUR = 2'd1,
        SET_MIN  = 2'd2
    } mode_t;

    mode_t          r_mode, w_mode_next;
    logic [PW-1:0]  r_presc, w_presc_next;
    logic [SW-1:0]  r_scan_cnt, w_scan_cnt_next;
    logic [1:0]     r_scan_idx, w_scan_idx_next;
    logic [7:0]     r_hour, r_min, r_sec;
    logic [7:0]     w_hour_next, w_min_next, w_sec_next;
    logic           r_mode_prev, r_inc_prev;
    logic [3:0]     r_digit_sel, r_digit_val;
    logic           w_tick, w_mode_edge, w_inc_edge, w_inc_ok, w_leave_set_min;
    logic           w_scan_wrap, w_blink, w_blank;
    logic [3:0]     w_digit, w_digit_val_next;

    // BCD increment that wraps to 00 after max_v; units 9 rolls into the tens digit.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max_v);
        logic [7:0] res;
        if (v == max_v)
            res = 8'h00;
        else if (v[3:0] == 4'd9)
            res = {v[7:4] + 4'd1, 4'd0};
        else
            res = {v[7:4], v[3:0] + 4'd1};
        return res;
    endfunction

    assign w_tick          = (r_presc == PW'(TICK_DIV - 1));
    assign w_mode_edge     = btn_mode & ~r_mode_prev;
    assign w_inc_edge      = btn_inc & ~r_inc_prev;
    assign w_inc_ok        = w_inc_edge & ~w_mode_edge;
    assign w_leave_set_min = (r_mode == SET_MIN) && w_mode_edge;
    assign w_scan_wrap     = (r_scan_cnt == SW'(SCAN_DIV - 1));

    always_comb begin
        w_mode_next = r_mode;
        case (r_mode)
            RUN:      if (w_mode_edge) w_mode_next = SET_HOUR;
            SET_HOUR: if (w_mode_edge) w_mode_next = SET_MIN;
            SET_MIN:  if (w_mode_edge) w_mode_next = RUN;
            default:  w_mode_next = RUN;
        endcase
    end

    always_comb begin
        w_presc_next = w_tick ? '0 : r_presc + PW'(1);
        if (w_leave_set_min)
            w_presc_next = '0;
    end

    always_comb begin
        w_sec_next  = r_sec;
        w_min_next  = r_min;
        w_hour_next = r_hour;
        case (r_mode)
            RUN: begin
                if (w_tick) begin
                    w_sec_next = bcd_inc(r_sec, 8'h59);
                    if (r_sec == 8'h59) begin
                        w_min_next = bcd_inc(r_min, 8'h59);
                        if (r_min == 8'h59)
                            w_hour_next = bcd_inc(r_hour, 8'h23);
                    end
                end
            end
            SET_HOUR: if (w_inc_ok) w_hour_next = bcd_inc(r_hour, 8'h23);
            SET_MIN: begin
                if (w_inc_ok)
                    w_min_next = bcd_inc(r_min, 8'h59);
                if (w_mode_edge)
                    w_sec_next = 8'h00;
            end
            default: ;
        endcase
    end

    // Display registers are loaded from next-state values so they line up with the time,
    // index and blink phase that become visible on the same edge.
    always_comb begin
        w_scan_cnt_next = w_scan_wrap ? '0 : r_scan_cnt + SW'(1);
        w_scan_idx_next = w_scan_wrap ? r_scan_idx + 2'd1 : r_scan_idx;
        w_blink         = (w_presc_next >= PW'(TICK_DIV / 2));
        case (w_scan_idx_next)
            2'd0:    w_digit = w_hour_next[7:4];
            2'd1:    w_digit = w_hour_next[3:0];
            2'd2:    w_digit = w_min_next[7:4];
            default: w_digit = w_min_next[3:0];
        endcase
        w_blank = w_blink &&
                  (((w_mode_next == SET_HOUR) && !w_scan_idx_next[1]) ||
                   ((w_mode_next == SET_MIN)  &&  w_scan_idx_next[1]));
        w_digit_val_next = w_blank ? 4'hF : w_digit;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_mode <= RUN;
        else
            r_mode <= w_mode_next;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_presc     <= '0;
            r_scan_cnt  <= '0;
            r_scan_idx  <= 2'd0;
            r_hour      <= 8'h00;
            r_min       <= 8'h00;
            r_sec       <= 8'h00;
            r_mode_prev <= 1'b0;
            r_inc_prev  <= 1'b0;
            r_digit_sel <= 4'b0001;
            r_digit_val <= 4'h0;
        end else begin
            r_presc     <= w_presc_next;
            r_scan_cnt  <= w_scan_cnt_next;
            r_scan_idx  <= w_scan_idx_next;
            r_hour      <= w_hour_next;
            r_min       <= w_min_next;
            r_sec       <= w_sec_next;
            r_mode_prev <= btn_mode;
            r_inc_prev  <= btn_inc;
            r_digit_sel <= 4'b0001 << w_scan_idx_next;
            r_digit_val <= w_digit_val_next;
        end
    end

    assign hour_bcd  = r_hour;
    assign min_bcd   = r_min;
    assign sec_bcd   = r_sec;
    assign mode      = r_mode;
    assign tick      = w_tick;
    assign led       = (r_presc < PW'(TICK_DIV / 2));
    assign digit_sel = r_digit_sel;
    assign digit_val = r_digit_val;

endmodule

// File: tb/tb_clock_set_controller.sv
// Directed bench for clock_set_controller with TICK_DIV=10, SCAN_DIV=4.
module tb_clock_set_controller;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       btn_mode = 1'b0;
    logic       btn_inc = 1'b0;
    logic [7:0] hour_bcd, min_bcd, sec_bcd;
    logic [1:0] mode;
    logic       tick, led;
    logic [3:0] digit_sel, digit_val;

    int n_cmp = 0;
    int n_err = 0;
    int cyc_cnt = 0;   // clk edges since reset release
    int p_model = 0;   // expected prescaler count

    clock_set_controller #(.TICK_DIV(10), .SCAN_DIV(4)) dut (
        .clk(clk), .rst(rst), .btn_mode(btn_mode), .btn_inc(btn_inc),
        .hour_bcd(hour_bcd), .min_bcd(min_bcd), .sec_bcd(sec_bcd),
        .mode(mode), .tick(tick), .led(led),
        .digit_sel(digit_sel), .digit_val(digit_val)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc_cnt);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(negedge clk);
            cyc_cnt++;
            p_model = (p_model + 1) % 10;
        end
    endtask

    task automatic press_mode(input bit clears_presc);
        btn_mode = 1'b1;
        cyc(1);
        if (clears_presc) p_model = 0;
        btn_mode = 1'b0;
        cyc(1);
    endtask

    task automatic press_inc(input int n);
        repeat (n) begin
            btn_inc = 1'b1;
            cyc(1);
            btn_inc = 1'b0;
            cyc(1);
        end
    endtask

    task automatic scan_check(input int n, input int md, input logic [7:0] h, input logic [7:0] m);
        int idx;
        logic [3:0] dig;
        logic [3:0] exp_sel;
        logic blank;
        repeat (n) begin
            cyc(1);
            idx = (cyc_cnt / 4) % 4;
            exp_sel = 4'b0001 << idx;
            case (idx)
                0:       dig = h[7:4];
                1:       dig = h[3:0];
                2:       dig = m[7:4];
                default: dig = m[3:0];
            endcase
            blank = (p_model >= 5) && (((md == 1) && (idx < 2)) || ((md == 2) && (idx >= 2)));
            chk("digit_sel", {4'h0, digit_sel}, {4'h0, exp_sel});
            chk("digit_val", {4'h0, digit_val}, {4'h0, (blank ? 4'hF : dig)});
            chk("led", {7'h0, led}, {7'h0, (p_model < 5)});
        end
    endtask

    initial begin
        // reset state
        repeat (3) @(negedge clk);
        chk("rst_mode", {6'h0, mode}, 8'h0);
        chk("rst_hour", hour_bcd, 8'h00);
        chk("rst_min", min_bcd, 8'h00);
        chk("rst_sec", sec_bcd, 8'h00);
        chk("rst_tick", {7'h0, tick}, 8'h0);
        chk("rst_led", {7'h0, led}, 8'h1);
        chk("rst_sel", {4'h0, digit_sel}, 8'h01);
        chk("rst_val", {4'h0, digit_val}, 8'h00);
        rst = 1'b1;
        cyc_cnt = 0;
        p_model = 0;

        // basic count
        cyc(8);
        chk("tick_c8", {7'h0, tick}, 8'h0);
        cyc(1);
        chk("tick_c9", {7'h0, tick}, 8'h1);
        chk("led_c9", {7'h0, led}, 8'h0);
        chk("sec_c9", sec_bcd, 8'h00);
        cyc(1);
        chk("sec_c10", sec_bcd, 8'h01);
        chk("tick_c10", {7'h0, tick}, 8'h0);
        cyc(590);
        chk("sec_c600", sec_bcd, 8'h00);
        chk("min_c600", min_bcd, 8'h01);
        chk("hour_c600", hour_bcd, 8'h00);
        scan_check(8, 0, 8'h00, 8'h01);
        cyc(42);
        chk("sec_c650", sec_bcd, 8'h05);

        // full rollover via set modes
        press_mode(1'b0);
        chk("mode_sh", {6'h0, mode}, 8'h1);
        press_inc(23);
        chk("hour_set23", hour_bcd, 8'h23);
        chk("sec_hold_sh", sec_bcd, 8'h05);
        press_mode(1'b0);
        chk("mode_sm", {6'h0, mode}, 8'h2);
        press_inc(58);
        chk("min_set59", min_bcd, 8'h59);
        press_inc(1);
        chk("min_wrap", min_bcd, 8'h00);
        chk("min_wrap_hour", hour_bcd, 8'h23);
        press_inc(59);
        chk("min_set59b", min_bcd, 8'h59);
        chk("sec_hold_sm", sec_bcd, 8'h05);
        btn_mode = 1'b1;
        cyc(1);
        p_model = 0;
        chk("mode_run", {6'h0, mode}, 8'h0);
        chk("sec_clr", sec_bcd, 8'h00);
        chk("led_clr", {7'h0, led}, 8'h1);
        btn_mode = 1'b0;
        cyc(1);
        cyc(589);
        chk("hour_235959", hour_bcd, 8'h23);
        chk("min_235959", min_bcd, 8'h59);
        chk("sec_235959", sec_bcd, 8'h59);
        cyc(9);
        chk("tick_roll", {7'h0, tick}, 8'h1);
        cyc(1);
        chk("hour_roll", hour_bcd, 8'h00);
        chk("min_roll", min_bcd, 8'h00);
        chk("sec_roll", sec_bcd, 8'h00);

        // simultaneous buttons, then held button
        btn_mode = 1'b1;
        btn_inc = 1'b1;
        cyc(1);
        chk("simul_mode", {6'h0, mode}, 8'h1);
        chk("simul_hour", hour_bcd, 8'h00);
        btn_mode = 1'b0;
        btn_inc = 1'b0;
        cyc(1);
        btn_inc = 1'b1;
        cyc(50);
        btn_inc = 1'b0;
        cyc(1);
        chk("held_hour", hour_bcd, 8'h01);
        press_inc(22);
        chk("hour_23", hour_bcd, 8'h23);
        press_inc(1);
        chk("hour_wrap", hour_bcd, 8'h00);
        chk("hour_wrap_min", min_bcd, 8'h00);

        // scan and blink at 12:34 in SET_HOUR
        press_inc(12);
        press_mode(1'b0);
        press_inc(34);
        press_mode(1'b1);
        press_mode(1'b0);
        chk("mode_1234", {6'h0, mode}, 8'h1);
        chk("hour_12", hour_bcd, 8'h12);
        chk("min_34", min_bcd, 8'h34);
        scan_check(40, 1, 8'h12, 8'h34);

        // async reset in SET_MIN at 07:42
        press_inc(19);
        press_mode(1'b0);
        press_inc(8);
        chk("hour_07", hour_bcd, 8'h07);
        chk("min_42", min_bcd, 8'h42);
        chk("mode_sm2", {6'h0, mode}, 8'h2);
        scan_check(12, 2, 8'h07, 8'h42);
        #2 rst = 1'b0;
        #1;
        chk("arst_mode", {6'h0, mode}, 8'h0);
        chk("arst_hour", hour_bcd, 8'h00);
        chk("arst_min", min_bcd, 8'h00);
        chk("arst_sec", sec_bcd, 8'h00);
        chk("arst_sel", {4'h0, digit_sel}, 8'h01);
        chk("arst_val", {4'h0, digit_val}, 8'h00);
        chk("arst_tick", {7'h0, tick}, 8'h0);
        btn_inc = 1'b1;
        btn_mode = 1'b1;
        repeat (3) @(negedge clk);
        chk("arst_hold_mode", {6'h0, mode}, 8'h0);
        chk("arst_hold_sel", {4'h0, digit_sel}, 8'h01);
        chk("arst_hold_min", min_bcd, 8'h00);
        btn_inc = 1'b0;
        btn_mode = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        cyc_cnt = 0;
        p_model = 0;
        cyc(10);
        chk("post_mode", {6'h0, mode}, 8'h0);
        chk("post_sec", sec_bcd, 8'h01);
        chk("post_hour", hour_bcd, 8'h00);
        scan_check(8, 0, 8'h00, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
